snake_engine: RTL
=================

SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 SHALL have parameter GRID_W, default 78, grid width in cells.
REQ-002 SHALL have parameter GRID_H, default 54, grid height in cells.
REQ-003 SHALL have parameter MAX_LEN, default 128, maximum segment count; LW = clog2(MAX_LEN+1).
REQ-004 SHALL have parameter INIT_X, default 40, head column after start.
REQ-005 SHALL have parameter INIT_Y, default 27, head row after start.
REQ-006 SHALL have parameter XW, default 7, column coordinate width; YW, default 6, row coordinate width.
REQ-007 SHALL have port clk  input  1  single clock.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port start  input  1  pulse; (re)initialise a game.
REQ-010 SHALL have port step  input  1  move tick.
REQ-011 SHALL have port dir  input  2  requested heading: 00 up, 01 left, 10 down, 11 right.
REQ-012 SHALL have port grow  input  1  grow request, sampled with step.
REQ-013 SHALL have ports qx  input  XW and qy  input  YW  pixel-scan query cell.
REQ-014 SHALL have port q_hit  output  1  registered occupancy of (qx,qy).
REQ-015 SHALL have ports head_x  output  XW and head_y  output  YW  current head cell.
REQ-016 SHALL have port length  output  LW  current segment count.
REQ-017 SHALL have ports busy, dead, moved  output  1 each  status flags.

Function
REQ-018 SHALL store segments in a MAX_LEN-entry ring buffer (head pointer, tail pointer) plus a GRID_W*GRID_H occupancy bitmap.
REQ-019 SHALL implement states IDLE, CLEAR, RUN, CHECK, DEAD.
REQ-020 CLEAR SHALL zero one bitmap cell per cycle, taking GRID_W*GRID_H cycles, with busy=1.
REQ-021 CLEAR exit SHALL go to RUN with a length-1 snake at (INIT_X,INIT_Y) and heading right if entered via start, else to IDLE with length 0.
REQ-022 start SHALL be accepted in IDLE, RUN, CHECK and DEAD, and SHALL abort any pending move; start during CLEAR SHALL restart the clear.
REQ-023 step SHALL be accepted only in RUN; step in any other state is ignored.
REQ-024 On accepted step: dir opposite to the current heading SHALL be ignored, else the heading SHALL update; next head = head +/-1 on one axis; FSM goes to CHECK.
REQ-025 CHECK SHALL read the bitmap at next head; a cell is lethal if occupied, unless grow=0 and it equals the tail cell.
REQ-026 Without wrap, a next head outside [0,GRID_W-1] x [0,GRID_H-1] SHALL be lethal.
REQ-027 Lethal move SHALL go to DEAD, set dead=1, and leave head, length and bitmap unchanged.
REQ-028 Non-lethal commit (cycle after CHECK): write head into the ring, set its bitmap bit, pulse moved for 1 cycle; head_x/head_y update 2 cycles after step.
REQ-029 grow=1 with length<MAX_LEN SHALL increment length and keep the tail; otherwise the tail bit SHALL be cleared and the tail advanced.
REQ-030 Head-set and tail-clear on the same cell in one cycle: set SHALL win.
REQ-031 q_hit SHALL equal the bitmap bit at (qx,qy) one cycle after the query, reflecting pre-commit state; out-of-grid query SHALL give 0.
REQ-032 busy SHALL be 1 in CLEAR and CHECK.
REQ-033 dead SHALL clear only on start or reset.

Reset
REQ-034 reset SHALL take priority over all inputs and enter CLEAR (non-start path).
REQ-035 On reset: length=0, dead=0, moved=0, q_hit=0, head_x=INIT_X, head_y=INIT_Y, heading right, pointers 0.

Configuration
REQ-036 Macro SNAKE_ENGINE_WRAP_EN defined: moving off an edge SHALL wrap (x: GRID_W-1<->0; y: GRID_H-1<->0) and is never lethal by bounds.
REQ-037 SNAKE_ENGINE_WRAP_EN undefined: off-edge moves SHALL be lethal per REQ-026.

Verification
REQ-038 reset, then start, then wait for busy=0 -> length=1, head=(40,27), q_hit=1 at (40,27) and 0 at (41,27).
REQ-039 3 steps dir=11 with grow=1 -> head=(43,27), length=4, moved pulses 3 times; 1 step dir=01 -> heading unchanged, head=(44,27).
REQ-040 Length-4 snake, steps tracing a square with grow=0 -> head enters the vacated tail cell, dead=0.
REQ-041 Head at (77,10), step right -> dead=1 without WRAP_EN; head=(0,10), dead=0 with WRAP_EN.
REQ-042 length=MAX_LEN, step with grow=1 -> length stays MAX_LEN and the tail advances.
REQ-043 start asserted in the CHECK cycle -> no moved pulse, CLEAR entered, then head=(40,27), length=1.

Source files
------------

// File: rtl/snake_engine.sv
// snake_engine: snake game core.
// Segments are kept in a MAX_LEN-entry ring buffer (head pointer, tail pointer)
// next to a GRID_W*GRID_H occupancy bitmap. A move is accepted in RUN, checked
// against the bitmap in CHECK, and committed on the edge that leaves CHECK.
// Optional feature macro: SNAKE_ENGINE_WRAP_EN (edges wrap instead of killing).
//
// Handshake: start and step are single-cycle requests sampled on the rising
// clock edge; there is no ready. step counts only when the engine is in RUN
// (busy=0, dead=0), start counts in every state and wins over step. The
// results of an accepted step appear one cycle after busy rises: moved pulses
// for one cycle on a legal move, dead rises and stays high on a lethal one.
module snake_engine #(
  parameter int GRID_W  = 78,
  parameter int GRID_H  = 54,
  parameter int MAX_LEN = 128,
  parameter int INIT_X  = 40,
  parameter int INIT_Y  = 27,
  parameter int XW      = 7,
  parameter int YW      = 6,
  localparam int LW     = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          step,
  input  logic [1:0]    dir,
  input  logic          grow,
  input  logic [XW-1:0] qx,
  input  logic [YW-1:0] qy,
  output logic          q_hit,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          busy,
  output logic          dead,
  output logic          moved,
  output logic [2:0]    dbg_state
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int CW    = $clog2(CELLS);
  localparam int PW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

`ifdef SNAKE_ENGINE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [1:0] HD_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DEAD  = 3'd4
  } state_t;

  state_t state, state_n;

  // storage
  logic          bitmap [CELLS];
  logic [XW-1:0] ring_x [MAX_LEN];
  logic [YW-1:0] ring_y [MAX_LEN];

  logic [CW-1:0] clr_idx;
  logic          from_start;
  logic [PW-1:0] hp, tp;
  logic [1:0]    heading;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          noob;
  logic          grow_r;

  // FSM decisions
  logic clr_restart, finish_clear, step_acc, commit, kill;

  // next-head candidate computed from current head
  logic [1:0]    hd_n;
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  logic          soob;

  logic [XW-1:0] tail_x;
  logic [YW-1:0] tail_y;
  logic          occ, at_tail, lethal, grow_ok;
  logic [PW-1:0] hp_inc, tp_inc;
  logic          q_in, q_val;

  function automatic logic [CW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return CW'(y) * CW'(GRID_W) + CW'(x);
  endfunction

  assign busy      = (state == S_CLEAR) || (state == S_CHECK);
  assign dbg_state = state;

  assign tail_x  = ring_x[tp];
  assign tail_y  = ring_y[tp];
  assign occ     = bitmap[cell_idx(nx, ny)];
  assign at_tail = (nx == tail_x) && (ny == tail_y);
  // the tail cell is vacated by this same move only when the snake is not growing
  assign lethal  = noob || (occ && !(!grow_r && at_tail));
  assign grow_ok = grow_r && (length < LW'(MAX_LEN));
  assign hp_inc  = (int'(hp) == MAX_LEN - 1) ? '0 : hp + PW'(1);
  assign tp_inc  = (int'(tp) == MAX_LEN - 1) ? '0 : tp + PW'(1);

  assign q_in  = (int'(qx) < GRID_W) && (int'(qy) < GRID_H);
  assign q_val = q_in ? bitmap[cell_idx(qx, qy)] : 1'b0;

  // heading filter and one-cell move with edge handling
  always_comb begin
    hd_n = (dir == {~heading[1], heading[0]}) ? heading : dir;
    sx   = head_x;
    sy   = head_y;
    soob = 1'b0;
    case (hd_n)
      2'b00: begin
        if (head_y == '0) begin
          sy   = YW'(GRID_H - 1);
          soob = ~WRAP;
        end else begin
          sy = head_y - YW'(1);
        end
      end
      2'b01: begin
        if (head_x == '0) begin
          sx   = XW'(GRID_W - 1);
          soob = ~WRAP;
        end else begin
          sx = head_x - XW'(1);
        end
      end
      2'b10: begin
        if (int'(head_y) == GRID_H - 1) begin
          sy   = '0;
          soob = ~WRAP;
        end else begin
          sy = head_y + YW'(1);
        end
      end
      default: begin
        if (int'(head_x) == GRID_W - 1) begin
          sx   = '0;
          soob = ~WRAP;
        end else begin
          sx = head_x + XW'(1);
        end
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_n;
  end

  // FSM next state and per-cycle decisions
  always_comb begin
    state_n      = state;
    clr_restart  = 1'b0;
    finish_clear = 1'b0;
    step_acc     = 1'b0;
    commit       = 1'b0;
    kill         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          clr_restart = 1'b1;
          state_n     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (start) begin
          clr_restart = 1'b1;
        end else if (int'(clr_idx) == CELLS - 1) begin
          finish_clear = 1'b1;
          state_n      = from_start ? S_RUN : S_IDLE;
        end
      end
      S_RUN: begin
        if (start) begin
          clr_restart = 1'b1;
          state_n     = S_CLEAR;
        end else if (step) begin
          step_acc = 1'b1;
          state_n  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (start) begin
          clr_restart = 1'b1;
          state_n     = S_CLEAR;
        end else if (lethal) begin
          kill    = 1'b1;
          state_n = S_DEAD;
        end else begin
          commit  = 1'b1;
          state_n = S_RUN;
        end
      end
      S_DEAD: begin
        if (start) begin
          clr_restart = 1'b1;
          state_n     = S_CLEAR;
        end
      end
      default: state_n = S_CLEAR;
    endcase
  end

  // control registers, snake geometry and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_idx    <= '0;
      from_start <= 1'b0;
      hp         <= '0;
      tp         <= '0;
      heading    <= HD_RIGHT;
      nx         <= '0;
      ny         <= '0;
      noob       <= 1'b0;
      grow_r     <= 1'b0;
      head_x     <= XW'(INIT_X);
      head_y     <= YW'(INIT_Y);
      length     <= '0;
      dead       <= 1'b0;
      moved      <= 1'b0;
      q_hit      <= 1'b0;
    end else begin
      moved <= commit;
      q_hit <= q_val;
      if (clr_restart) begin
        clr_idx    <= '0;
        from_start <= 1'b1;
        dead       <= 1'b0;
      end else if (state == S_CLEAR) begin
        clr_idx <= clr_idx + CW'(1);
      end
      if (finish_clear) begin
        hp      <= '0;
        tp      <= '0;
        heading <= HD_RIGHT;
        head_x  <= XW'(INIT_X);
        head_y  <= YW'(INIT_Y);
        length  <= from_start ? LW'(1) : '0;
      end
      if (step_acc) begin
        heading <= hd_n;
        nx      <= sx;
        ny      <= sy;
        noob    <= soob;
        grow_r  <= grow;
      end
      if (kill) begin
        dead <= 1'b1;
      end
      if (commit) begin
        hp     <= hp_inc;
        head_x <= nx;
        head_y <= ny;
        if (grow_ok) length <= length + LW'(1);
        else         tp     <= tp_inc;
      end
    end
  end

  // bitmap and ring storage; head set is written last so it wins over tail clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR && !start) begin
        bitmap[clr_idx] <= 1'b0;
      end
      if (finish_clear && from_start) begin
        ring_x[0] <= XW'(INIT_X);
        ring_y[0] <= YW'(INIT_Y);
        bitmap[cell_idx(XW'(INIT_X), YW'(INIT_Y))] <= 1'b1;
      end
      if (commit) begin
        ring_x[hp_inc] <= nx;
        ring_y[hp_inc] <= ny;
        if (!grow_ok) bitmap[cell_idx(tail_x, tail_y)] <= 1'b0;
        bitmap[cell_idx(nx, ny)] <= 1'b1;
      end
    end
  end

endmodule
